addsub_arbiter: RTL and testbench

Two-requester controller that shares one WIDTH-bit add/subtract datapath (a, b, sub → sum) between independent clients. It accepts operations over valid/ready request channels, arbitrates round-robin, latches operands, registers the result and returns it on a single tagged response channel. It sits between lab-level stimulus or controller logic and the shared adder, so that only one adder instance is needed per design.

---
 rtl/addsub_arbiter.sv | 114 +++++++++++
 tb/tb_addsub_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for one shared WIDTH-bit add/subtract datapath.
// Define ADDSUB_ARB_OVF_EN to add the registered signed-overflow output rsp_ovf.
module addsub_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
`ifdef ADDSUB_ARB_OVF_EN
   output logic             rsp_ovf,
`endif
   output logic [WIDTH-1:0] rsp_sum
);

   typedef enum logic [1:0] {StIdle, StCalc, StResp} state_t;

   state_t           state_q;
   logic             last_id_q;
   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic             op_sub_q;
   logic             op_id_q;

   logic             grant0;
   logic             grant1;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] sum;

   // On a tie the requester that was not granted last time wins.
   always_comb begin
      grant0 = req0_valid & (~req1_valid | last_id_q);
      grant1 = req1_valid & (~req0_valid | ~last_id_q);
   end

   // Reset wins over an accept, so ready is withheld while rst is high.
   assign req0_ready = (state_q == StIdle) & grant0 & ~rst;
   assign req1_ready = (state_q == StIdle) & grant1 & ~rst;

   // Subtraction as a + ~b + 1, carry-in supplied by op_sub_q.
   always_comb begin
      b_eff = op_sub_q ? ~op_b_q : op_b_q;
      sum   = op_a_q + b_eff + {{(WIDTH-1){1'b0}}, op_sub_q};
   end

`ifdef ADDSUB_ARB_OVF_EN
   logic ovf;
   always_comb begin
      if (op_sub_q) begin
         ovf = (op_a_q[WIDTH-1] != op_b_q[WIDTH-1]) & (sum[WIDTH-1] != op_a_q[WIDTH-1]);
      end else begin
         ovf = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) & (sum[WIDTH-1] != op_a_q[WIDTH-1]);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         last_id_q <= 1'b1;
         op_a_q    <= '0;
         op_b_q    <= '0;
         op_sub_q  <= 1'b0;
         op_id_q   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_sum   <= '0;
`ifdef ADDSUB_ARB_OVF_EN
         rsp_ovf   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant0 | grant1) begin
                  op_a_q    <= grant1 ? req1_a : req0_a;
                  op_b_q    <= grant1 ? req1_b : req0_b;
                  op_sub_q  <= grant1 ? req1_sub : req0_sub;
                  op_id_q   <= grant1;
                  last_id_q <= grant1;
                  state_q   <= StCalc;
               end
            end
            StCalc: begin
               rsp_sum   <= sum;
               rsp_id    <= op_id_q;
               rsp_valid <= 1'b1;
`ifdef ADDSUB_ARB_OVF_EN
               rsp_ovf   <= ovf;
`endif
               state_q   <= StResp;
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter; overflow cases build only with
// ADDSUB_ARB_OVF_EN defined.
module tb_addsub_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_sub;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready, req1_sub;
   logic [31:0] req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf;
   logic [31:0] rsp_sum;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   addsub_arbiter #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sub   (req0_sub),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sub   (req1_sub),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
`ifdef ADDSUB_ARB_OVF_EN
      .rsp_ovf    (rsp_ovf),
`endif
      .rsp_sum    (rsp_sum)
   );

`ifndef ADDSUB_ARB_OVF_EN
   assign rsp_ovf = 1'b0;
`endif

   // Issue one operation from requester id with rsp_ready already high, capture the response.
   task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, output logic got_ready, output int lat,
                         output logic rid, output logic [31:0] rs, output logic ro);
      @(negedge clk);
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
      end
      #1 got_ready = id ? req1_ready : req0_ready;
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!rsp_valid) lat = -1;
      rid = rsp_id;
      rs  = rsp_sum;
      ro  = rsp_ovf;
      @(posedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid);
      end
      total++;
      if (rsp_id !== 1'b0) begin
         bad++; $display("FAIL reset_rsp_id got=%b want=0", rsp_id);
      end
      total++;
      if (rsp_sum !== 32'h0) begin
         bad++; $display("FAIL reset_rsp_sum got=%h want=00000000", rsp_sum);
      end
      total++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         bad++; $display("FAIL reset_ready got=%b%b want=00", req0_ready, req1_ready);
      end
`ifdef ADDSUB_ARB_OVF_EN
      total++;
      if (rsp_ovf !== 1'b0) begin
         bad++; $display("FAIL reset_rsp_ovf got=%b want=0", rsp_ovf);
      end
`endif
   endtask

   task automatic test_single();
      logic gr, rid, ro;
      int lat;
      logic [31:0] rs;
      rsp_ready = 1'b1;
      run_op(1'b0, 32'd1, 32'd0, 1'b0, gr, lat, rid, rs, ro);
      total++;
      if (gr !== 1'b1) begin
         bad++; $display("FAIL single_ready got=%b want=1", gr);
      end
      total++;
      if (lat != 2) begin
         bad++; $display("FAIL single_latency got=%0d want=2", lat);
      end
      total++;
      if (rid !== 1'b0 || rs !== 32'h1) begin
         bad++; $display("FAIL single_rsp got id=%b sum=%h want id=0 sum=00000001", rid, rs);
      end
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++; $display("FAIL single_consumed got=%b want=0", rsp_valid);
      end
   endtask

   task automatic test_sub_wrap();
      logic gr, rid, ro;
      int lat;
      logic [31:0] rs;
      run_op(1'b1, 32'h0001_0000, 32'h1, 1'b1, gr, lat, rid, rs, ro);
      total++;
      if (gr !== 1'b1 || rid !== 1'b1 || rs !== 32'h0000_FFFF) begin
         bad++; $display("FAIL sub_basic got rdy=%b id=%b sum=%h want rdy=1 id=1 sum=0000ffff",
                         gr, rid, rs);
      end
      run_op(1'b0, 32'h0, 32'h1, 1'b1, gr, lat, rid, rs, ro);
      total++;
      if (rid !== 1'b0 || rs !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL sub_wrap got id=%b sum=%h want id=0 sum=ffffffff", rid, rs);
      end
      run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, gr, lat, rid, rs, ro);
      total++;
      if (rid !== 1'b1 || rs !== 32'hFFFF_FFFE) begin
         bad++; $display("FAIL add_wrap got id=%b sum=%h want id=1 sum=fffffffe", rid, rs);
      end
   endtask

   task automatic test_contention();
      logic        ids [4];
      logic [31:0] sums [4];
      int          at [4];
      logic        exp_id [4];
      logic [31:0] exp_sum [4];
      int n = 0;
      int cyc = 0;
      exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_sum = '{32'd4, 32'd2, 32'd4, 32'd2};
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_sub = 1'b0;
      req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd3; req1_sub = 1'b1;
      rsp_ready  = 1'b1;
      while (n < 4 && cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (rsp_valid) begin
            ids[n] = rsp_id; sums[n] = rsp_sum; at[n] = cyc; n++;
         end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      total++;
      if (n != 4) begin
         bad++; $display("FAIL contention_count got=%0d want=4", n);
      end
      for (int i = 0; i < n; i++) begin
         total++;
         if (ids[i] !== exp_id[i] || sums[i] !== exp_sum[i]) begin
            bad++; $display("FAIL contention_rsp%0d got id=%b sum=%h want id=%b sum=%h",
                            i, ids[i], sums[i], exp_id[i], exp_sum[i]);
         end
      end
      for (int i = 0; i + 1 < n; i++) begin
         total++;
         if (at[i+1] - at[i] != 3) begin
            bad++; $display("FAIL contention_gap%0d got=%0d want=3", i, at[i+1] - at[i]);
         end
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_backpressure();
      int k = 0;
      int stall_bad = 0;
      @(negedge clk);
      rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd8; req1_sub = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req1_valid = 1'b0;
      while (!rsp_valid && k < 10) begin
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_sub = 1'b0;
      req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd1; req1_sub = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_sum !== 32'd15 || rsp_id !== 1'b1 ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0) stall_bad++;
      end
      total++;
      if (stall_bad != 0) begin
         bad++; $display("FAIL backpressure_hold got %0d bad cycles (last v=%b sum=%h id=%b rdy=%b%b) want 0",
                         stall_bad, rsp_valid, rsp_sum, rsp_id, req0_ready, req1_ready);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++; $display("FAIL backpressure_release got=%b want=0", rsp_valid);
      end
      total++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         bad++; $display("FAIL backpressure_next_grant got=%b%b want=10", req0_ready, req1_ready);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

`ifdef ADDSUB_ARB_OVF_EN
   task automatic test_overflow();
      logic gr, rid, ro;
      int lat;
      logic [31:0] rs;
      run_op(1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, gr, lat, rid, rs, ro);
      total++;
      if (rs !== 32'h8000_0000 || ro !== 1'b1) begin
         bad++; $display("FAIL ovf_add_pos got sum=%h ovf=%b want 80000000 1", rs, ro);
      end
      run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, gr, lat, rid, rs, ro);
      total++;
      if (rs !== 32'hFFFF_FFFE || ro !== 1'b0) begin
         bad++; $display("FAIL ovf_add_neg got sum=%h ovf=%b want fffffffe 0", rs, ro);
      end
      run_op(1'b0, 32'h8000_0000, 32'h1, 1'b1, gr, lat, rid, rs, ro);
      total++;
      if (rs !== 32'h7FFF_FFFF || ro !== 1'b1) begin
         bad++; $display("FAIL ovf_sub got sum=%h ovf=%b want 7fffffff 1", rs, ro);
      end
   endtask
`endif

   task automatic test_reset_mid();
      logic gr, rid, ro;
      int lat;
      int k = 0;
      int seen = 0;
      logic [31:0] rs;
      rsp_ready = 1'b1;
      run_op(1'b1, 32'd5, 32'd6, 1'b0, gr, lat, rid, rs, ro);
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_sub = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_sum !== 32'h0 || rsp_ovf !== 1'b0) begin
         bad++; $display("FAIL midreset_outputs got v=%b id=%b sum=%h ovf=%b want 0 0 00000000 0",
                         rsp_valid, rsp_id, rsp_sum, rsp_ovf);
      end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++; $display("FAIL midreset_dropped got %0d valid cycles want 0", seen);
      end
      req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_sub = 1'b0;
      req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_sub = 1'b0;
      #1;
      total++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         bad++; $display("FAIL midreset_tie got=%b%b want=10", req0_ready, req1_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      while (!rsp_valid && k < 10) begin
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_sum !== 32'd5) begin
         bad++; $display("FAIL midreset_next_rsp got v=%b id=%b sum=%h want 1 0 00000005",
                         rsp_valid, rsp_id, rsp_sum);
      end
      @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_sub_wrap();
      test_contention();
      test_backpressure();
`ifdef ADDSUB_ARB_OVF_EN
      test_overflow();
`endif
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
